// File: rtl/conv_psum_accumulator.sv
// Channel-wrap partial-sum accumulator: sums N_KERNEL lanes over a configured number of
// wraps, adds bias, requantises each lane and queues tiles in a show-ahead output FIFO.
module conv_psum_accumulator #(
    parameter int N_KERNEL   = 4,
    parameter int B_PIXEL    = 16,
    parameter int B_ACC      = 32,
    parameter int B_WRAP     = 7,
    parameter int B_SHIFT    = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         cfg_valid,
    output logic                         cfg_ready,
    input  logic [B_WRAP-1:0]            cfg_n_wrap,
    input  logic [B_SHIFT-1:0]           cfg_shift,
    input  logic                         cfg_relu,
    input  logic [N_KERNEL*B_ACC-1:0]    cfg_bias,
    input  logic                         flush,
    input  logic                         psum_valid,
    input  logic [N_KERNEL*B_ACC-1:0]    psum_i,
    output logic                         psum_stall,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [N_KERNEL*B_PIXEL-1:0]  out_data,
    output logic                         busy,
    output logic                         sat_flag
);

    localparam int ACC_W = B_ACC + B_WRAP;
    localparam int SUM_W = ACC_W + 1;
    localparam int RQ_W  = SUM_W + 1;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic signed [RQ_W-1:0] PIX_MAX = (RQ_W'(1) <<< (B_PIXEL - 1)) - RQ_W'(1);
    localparam logic signed [RQ_W-1:0] PIX_MIN = -PIX_MAX - RQ_W'(1);

    typedef enum logic {IDLE, ACCUM} state_e;

    logic [B_WRAP-1:0]            n_wrap_q;
    logic [B_SHIFT-1:0]           shift_q;
    logic                         relu_q;
    logic [N_KERNEL*B_ACC-1:0]    bias_q;
    logic                         sat_q;

    logic [B_WRAP-1:0]            wrap_cnt_q, wrap_cnt_d;
    logic signed [ACC_W-1:0]      acc_q [N_KERNEL];
    logic signed [ACC_W-1:0]      acc_d [N_KERNEL];
    logic                         pp_valid_q, pp_valid_d;
    logic signed [SUM_W-1:0]      pp_sum_q [N_KERNEL];
    logic signed [SUM_W-1:0]      pp_sum_d [N_KERNEL];

    logic [N_KERNEL*B_PIXEL-1:0]  fifo_q [FIFO_DEPTH];
    logic [PTR_W-1:0]             wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]             count_q;

    state_e                       state;
    logic                         cfg_load, beat_fire, final_beat, push, pop, pp_sat;
    logic [B_WRAP-1:0]            last_idx;
    logic [CNT_W:0]               occupancy;
    logic signed [B_ACC-1:0]      psum_lane [N_KERNEL];
    logic signed [B_ACC-1:0]      bias_lane [N_KERNEL];
    logic [B_PIXEL:0]             rq_res [N_KERNEL];
    logic [N_KERNEL-1:0]          sat_vec;
    logic [N_KERNEL*B_PIXEL-1:0]  pp_tile;

    // Returns {clamped, pixel}: rounding shift, optional ReLU, then saturation.
    function automatic logic [B_PIXEL:0] requant(input logic signed [SUM_W-1:0] sum,
                                                 input logic [B_SHIFT-1:0] sh,
                                                 input logic relu);
        logic signed [RQ_W-1:0] r;
        r = RQ_W'(sum);
        if (sh != '0) begin
            r = (r + (RQ_W'(1) <<< (sh - B_SHIFT'(1)))) >>> sh;
        end
        if (relu && r[RQ_W-1]) begin
            r = '0;
        end
        if (r > PIX_MAX) begin
            return {1'b1, PIX_MAX[B_PIXEL-1:0]};
        end else if (r < PIX_MIN) begin
            return {1'b1, PIX_MIN[B_PIXEL-1:0]};
        end
        return {1'b0, r[B_PIXEL-1:0]};
    endfunction

    assign state      = (wrap_cnt_q == '0) ? IDLE : ACCUM;
    assign cfg_ready  = (state == IDLE);
    assign cfg_load   = cfg_valid && cfg_ready;
    assign last_idx   = (n_wrap_q == '0) ? '0 : n_wrap_q - B_WRAP'(1);
    assign occupancy  = {1'b0, count_q} + {{CNT_W{1'b0}}, pp_valid_q};
    assign psum_stall = (occupancy >= (CNT_W + 1)'(FIFO_DEPTH));
    assign beat_fire  = psum_valid && !psum_stall && !flush;
    assign final_beat = beat_fire && (wrap_cnt_q == last_idx);

    for (genvar k = 0; k < N_KERNEL; k++) begin : g_lane
        assign psum_lane[k] = psum_i[k*B_ACC +: B_ACC];
        assign bias_lane[k] = bias_q[k*B_ACC +: B_ACC];
        assign rq_res[k]    = requant(pp_sum_q[k], shift_q, relu_q);
        assign pp_tile[k*B_PIXEL +: B_PIXEL] = rq_res[k][B_PIXEL-1:0];
        assign sat_vec[k]   = rq_res[k][B_PIXEL];
    end
    assign pp_sat = |sat_vec;

    // The final beat folds acc, psum and bias straight into the post-process stage
    // and clears acc in the same cycle, so back-to-back tiles need no bubble.
    always_comb begin
        wrap_cnt_d = wrap_cnt_q;
        pp_valid_d = 1'b0;
        for (int k = 0; k < N_KERNEL; k++) begin
            acc_d[k]    = acc_q[k];
            pp_sum_d[k] = pp_sum_q[k];
        end
        if (flush) begin
            wrap_cnt_d = '0;
            for (int k = 0; k < N_KERNEL; k++) acc_d[k] = '0;
        end else if (beat_fire) begin
            if (final_beat) begin
                wrap_cnt_d = '0;
                pp_valid_d = 1'b1;
                for (int k = 0; k < N_KERNEL; k++) begin
                    pp_sum_d[k] = SUM_W'(acc_q[k]) + SUM_W'(psum_lane[k]) + SUM_W'(bias_lane[k]);
                    acc_d[k]    = '0;
                end
            end else begin
                wrap_cnt_d = wrap_cnt_q + B_WRAP'(1);
                for (int k = 0; k < N_KERNEL; k++) acc_d[k] = acc_q[k] + ACC_W'(psum_lane[k]);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wrap_cnt_q <= '0;
            pp_valid_q <= 1'b0;
            for (int k = 0; k < N_KERNEL; k++) begin
                acc_q[k]    <= '0;
                pp_sum_q[k] <= '0;
            end
        end else begin
            wrap_cnt_q <= wrap_cnt_d;
            pp_valid_q <= pp_valid_d;
            for (int k = 0; k < N_KERNEL; k++) begin
                acc_q[k]    <= acc_d[k];
                pp_sum_q[k] <= pp_sum_d[k];
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            n_wrap_q <= '0;
            shift_q  <= '0;
            relu_q   <= 1'b0;
            bias_q   <= '0;
            sat_q    <= 1'b0;
        end else begin
            if (cfg_load) begin
                n_wrap_q <= cfg_n_wrap;
                shift_q  <= cfg_shift;
                relu_q   <= cfg_relu;
                bias_q   <= cfg_bias;
                sat_q    <= pp_valid_q && pp_sat;
            end else if (pp_valid_q && pp_sat) begin
                sat_q <= 1'b1;
            end
        end
    end

    // The stall keeps occupancy within FIFO_DEPTH, so the post-process push never blocks.
    assign push = pp_valid_q;
    assign pop  = out_valid && out_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            if (push) begin
                fifo_q[wr_ptr_q] <= pp_tile;
                wr_ptr_q         <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign out_valid = (count_q != '0);
    assign out_data  = out_valid ? fifo_q[rd_ptr_q] : '0;
    assign busy      = (state == ACCUM) || pp_valid_q || (count_q != '0);
    assign sat_flag  = sat_q;

endmodule

// File: tb/tb_conv_psum_accumulator.sv
// Randomised and directed bench for conv_psum_accumulator against a tile-level
// reference model (queue of finished tiles with their visibility cycle).
module tb_conv_psum_accumulator;

    localparam int NK  = 4;
    localparam int BP  = 16;
    localparam int BA  = 32;
    localparam int BW  = 7;
    localparam int BS  = 5;
    localparam int FD  = 4;
    localparam int INF = 32'h7fffffff;

    logic              clk = 1'b0;
    logic              rstn = 1'b0;
    logic              cfg_valid = 1'b0;
    logic              cfg_ready;
    logic [BW-1:0]     cfg_n_wrap = '0;
    logic [BS-1:0]     cfg_shift = '0;
    logic              cfg_relu = 1'b0;
    logic [NK*BA-1:0]  cfg_bias = '0;
    logic              flush = 1'b0;
    logic              psum_valid = 1'b0;
    logic [NK*BA-1:0]  psum_i = '0;
    logic              psum_stall;
    logic              out_valid;
    logic              out_ready;
    logic [NK*BP-1:0]  out_data;
    logic              busy;
    logic              sat_flag;

    logic randReady = 1'b0;
    logic rndBit = 1'b0;
    logic fixedReady = 1'b1;
    logic checkEn = 1'b0;
    logic logEn = 1'b0;
    logic [15:0] obs[$];

    int nVectors = 0;
    int nErrors = 0;

    assign out_ready = randReady ? rndBit : fixedReady;

    always #5 clk = ~clk;

    conv_psum_accumulator #(
        .N_KERNEL(NK), .B_PIXEL(BP), .B_ACC(BA), .B_WRAP(BW), .B_SHIFT(BS), .FIFO_DEPTH(FD)
    ) dut (
        .clk(clk), .rstn(rstn), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
        .cfg_n_wrap(cfg_n_wrap), .cfg_shift(cfg_shift), .cfg_relu(cfg_relu), .cfg_bias(cfg_bias),
        .flush(flush), .psum_valid(psum_valid), .psum_i(psum_i), .psum_stall(psum_stall),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .sat_flag(sat_flag)
    );

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        nVectors++;
        if (act !== exp) begin
            nErrors++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reportTimeout(input string name);
        nVectors++;
        nErrors++;
        $display("[TB] FAIL %s: wait bound expired at %0t", name, $time);
    endtask

    // ---------------- reference model ----------------
    int          cyc = 0;
    int          mWrap = 0;
    longint      mAcc [NK];
    int          mNwrap = 0;
    int          mShift = 0;
    bit          mRelu = 1'b0;
    longint      mBias [NK];
    logic [63:0] qData[$];
    int          qReady[$];
    int          mSatFrom = INF;

    bit          popNow, stallNow, wasIdle, anySat, laneSat;
    int          nwEff;
    logic [63:0] tile;

    function automatic logic [15:0] requantRef(input longint s, input int sh, input bit relu,
                                               output bit sat);
        longint r;
        r = s;
        if (sh > 0) r = (s + (64'sd1 <<< (sh - 1))) >>> sh;
        if (relu && r < 0) r = 0;
        sat = 1'b0;
        if (r > 32767) begin r = 32767; sat = 1'b1; end
        else if (r < -32768) begin r = -32768; sat = 1'b1; end
        return r[15:0];
    endfunction

    // A tile whose final beat is taken on an edge becomes visible two edges later;
    // the tile counts against the stall threshold from the edge it was completed.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            mWrap = 0;
            mNwrap = 0;
            mShift = 0;
            mRelu = 1'b0;
            mSatFrom = INF;
            for (int l = 0; l < NK; l++) begin mAcc[l] = 0; mBias[l] = 0; end
            qData.delete();
            qReady.delete();
        end else begin
            popNow   = (qData.size() > 0) && (qReady[0] <= cyc) && (out_ready === 1'b1);
            stallNow = (qData.size() >= FD);
            wasIdle  = (mWrap == 0);
            if (flush) begin
                mWrap = 0;
                for (int l = 0; l < NK; l++) mAcc[l] = 0;
            end else if (psum_valid && !stallNow) begin
                nwEff = (mNwrap == 0) ? 1 : mNwrap;
                for (int l = 0; l < NK; l++) mAcc[l] += longint'($signed(psum_i[l*BA +: BA]));
                mWrap++;
                if (mWrap >= nwEff) begin
                    tile = '0;
                    anySat = 1'b0;
                    for (int l = 0; l < NK; l++) begin
                        tile[l*16 +: 16] = requantRef(mAcc[l] + mBias[l], mShift, mRelu, laneSat);
                        anySat |= laneSat;
                        mAcc[l] = 0;
                    end
                    qData.push_back(tile);
                    qReady.push_back(cyc + 2);
                    if (anySat && mSatFrom == INF) mSatFrom = cyc + 2;
                    mWrap = 0;
                end
            end
            if (cfg_valid && wasIdle) begin
                mNwrap = int'(cfg_n_wrap);
                mShift = int'(cfg_shift);
                mRelu  = cfg_relu;
                mSatFrom = INF;
                for (int l = 0; l < NK; l++) mBias[l] = longint'($signed(cfg_bias[l*BA +: BA]));
            end
            if (popNow) begin
                void'(qData.pop_front());
                void'(qReady.pop_front());
            end
            cyc++;
        end
    end

    // Every-cycle comparison of all outputs against the model.
    always @(negedge clk) begin
        if (checkEn) begin
            automatic bit expValid = (qData.size() > 0) && (qReady[0] <= cyc);
            automatic logic [63:0] expData = expValid ? qData[0] : 64'd0;
            checkOutput("out_valid", 64'(out_valid), 64'(expValid));
            checkOutput("out_data", out_data, expData);
            checkOutput("psum_stall", 64'(psum_stall), 64'(qData.size() >= FD));
            checkOutput("cfg_ready", 64'(cfg_ready), 64'(mWrap == 0));
            checkOutput("busy", 64'(busy), 64'((mWrap != 0) || (qData.size() > 0)));
            checkOutput("sat_flag", 64'(sat_flag), 64'(cyc >= mSatFrom));
        end
    end

    always @(negedge clk) rndBit = 1'($urandom_range(0, 1));

    always @(posedge clk) begin
        if (logEn && out_valid && out_ready) obs.push_back(out_data[15:0]);
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [127:0] mk4(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [63:0] out4(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    function automatic logic [31:0] randLane();
        if ($urandom_range(0, 3) == 0) return 32'($urandom);
        return 32'(int'($urandom_range(0, 200000)) - 100000);
    endfunction

    task automatic loadCfg(input int nw, input int sh, input bit relu, input logic [127:0] bias);
        int guard = 0;
        @(negedge clk);
        while ((busy || !cfg_ready) && guard < 2000) begin @(negedge clk); guard++; end
        if (guard >= 2000) reportTimeout("cfg_wait");
        cfg_valid = 1'b1;
        cfg_n_wrap = BW'(nw);
        cfg_shift = BS'(sh);
        cfg_relu = relu;
        cfg_bias = bias;
        @(posedge clk);
        #1 cfg_valid = 1'b0;
    endtask

    task automatic applyStimulus(input logic [127:0] beat);
        int guard = 0;
        @(negedge clk);
        psum_valid = 1'b1;
        psum_i = beat;
        while (psum_stall && guard < 300) begin @(negedge clk); guard++; end
        if (guard >= 300) reportTimeout("beat_wait");
        @(posedge clk);
        #1 psum_valid = 1'b0;
    endtask

    task automatic doFlush(input bit withBeat);
        @(negedge clk);
        flush = 1'b1;
        psum_valid = withBeat;
        psum_i = {randLane(), randLane(), randLane(), randLane()};
        @(posedge clk);
        #1;
        flush = 1'b0;
        psum_valid = 1'b0;
    endtask

    task automatic expectTile(input string name, input logic [63:0] exp);
        int guard = 0;
        @(negedge clk);
        while (!out_valid && guard < 50) begin @(negedge clk); guard++; end
        if (guard >= 50) reportTimeout(name);
        else checkOutput(name, out_data, exp);
    endtask

    task automatic waitIdle(input string name);
        int guard = 0;
        @(negedge clk);
        while (busy && guard < 1000) begin @(negedge clk); guard++; end
        if (guard >= 1000) reportTimeout(name);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int nwCur;
        repeat (2) @(negedge clk);
        checkOutput("rst_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("rst_stall", 64'(psum_stall), 64'd0);
        checkOutput("rst_busy", 64'(busy), 64'd0);
        checkOutput("rst_sat", 64'(sat_flag), 64'd0);
        checkOutput("rst_out_data", out_data, 64'd0);
        rstn = 1'b1;
        checkEn = 1'b1;

        // Three-wrap tile and its two-cycle latency.
        loadCfg(3, 0, 1'b0, '0);
        applyStimulus(mk4(10, 1, 1, 1));
        applyStimulus(mk4(20, 1, 1, 1));
        applyStimulus(mk4(30, 1, 1, 1));
        @(negedge clk);
        checkOutput("lat_pp_stage", 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput("lat_out_valid", 64'(out_valid), 64'd1);
        checkOutput("tile_sum", out_data, out4(60, 3, 3, 3));

        // Rounding shift and ReLU.
        loadCfg(1, 2, 1'b0, '0);
        applyStimulus(mk4(6, 6, 6, 6));
        expectTile("round_pos", out4(2, 2, 2, 2));
        applyStimulus(mk4(-6, -6, -6, -6));
        expectTile("round_neg", out4(-1, -1, -1, -1));
        applyStimulus(mk4(5, 5, 5, 5));
        expectTile("round_half", out4(1, 1, 1, 1));
        loadCfg(1, 2, 1'b1, '0);
        applyStimulus(mk4(-100, -100, -100, -100));
        expectTile("relu_clamp", out4(0, 0, 0, 0));
        checkOutput("relu_no_sat", 64'(sat_flag), 64'd0);

        // Saturation and sticky flag cleared by config load.
        loadCfg(1, 0, 1'b0, '0);
        applyStimulus(mk4(40000, 40000, 40000, 40000));
        expectTile("sat_pos", out4(32767, 32767, 32767, 32767));
        checkOutput("sat_set", 64'(sat_flag), 64'd1);
        applyStimulus(mk4(-40000, -40000, -40000, -40000));
        expectTile("sat_neg", out4(-32768, -32768, -32768, -32768));
        loadCfg(1, 0, 1'b0, '0);
        @(negedge clk);
        checkOutput("sat_cleared", 64'(sat_flag), 64'd0);

        // Backpressure: fill, hold, then drain in order.
        waitIdle("bp_idle");
        obs.delete();
        logEn = 1'b1;
        fixedReady = 1'b0;
        for (int v = 1; v <= 4; v++) applyStimulus(mk4(v, v, v, v));
        @(negedge clk);
        psum_valid = 1'b1;
        psum_i = mk4(5, 5, 5, 5);
        checkOutput("bp_stall", 64'(psum_stall), 64'd1);
        repeat (3) @(negedge clk);
        checkOutput("bp_stall_hold", 64'(psum_stall), 64'd1);
        checkOutput("bp_head", out_data, out4(1, 1, 1, 1));
        psum_valid = 1'b0;
        fixedReady = 1'b1;
        for (int v = 5; v <= 8; v++) applyStimulus(mk4(v, v, v, v));
        waitIdle("bp_drain");
        logEn = 1'b0;
        checkOutput("bp_count", 64'(obs.size()), 64'd8);
        for (int i = 0; i < obs.size(); i++) checkOutput("bp_order", 64'(obs[i]), 64'(i + 1));

        // Flush of a partial tile (with a same-cycle beat that must be dropped).
        loadCfg(3, 0, 1'b0, '0);
        obs.delete();
        logEn = 1'b1;
        applyStimulus(mk4(5, 5, 5, 5));
        applyStimulus(mk4(5, 5, 5, 5));
        @(negedge clk);
        checkOutput("flush_cfg_busy", 64'(cfg_ready), 64'd0);
        doFlush(1'b1);
        @(negedge clk);
        checkOutput("flush_cfg_ready", 64'(cfg_ready), 64'd1);
        for (int i = 0; i < 3; i++) applyStimulus(mk4(1, 1, 1, 1));
        expectTile("flush_tile", out4(3, 3, 3, 3));
        waitIdle("flush_drain");
        logEn = 1'b0;
        checkOutput("flush_single", 64'(obs.size()), 64'd1);

        // Asynchronous reset mid-tile with two tiles queued.
        loadCfg(2, 0, 1'b0, '0);
        fixedReady = 1'b0;
        for (int v = 1; v <= 5; v++) applyStimulus(mk4(v, v, v, v));
        repeat (2) @(negedge clk);
        checkOutput("prerst_busy", 64'(busy), 64'd1);
        checkOutput("prerst_cfg_ready", 64'(cfg_ready), 64'd0);
        #3 rstn = 1'b0;
        #1;
        checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
        checkOutput("arst_busy", 64'(busy), 64'd0);
        checkOutput("arst_cfg_ready", 64'(cfg_ready), 64'd1);
        checkOutput("arst_out_data", out_data, 64'd0);
        @(negedge clk);
        rstn = 1'b1;
        fixedReady = 1'b1;
        applyStimulus(mk4(7, 7, 7, 7));
        expectTile("post_rst_tile", out4(7, 7, 7, 7));

        // Randomised traffic with random consumer readiness.
        randReady = 1'b1;
        nwCur = 1;
        for (int t = 0; t < 60; t++) begin
            if (t % 5 == 0) begin
                automatic int nw = int'($urandom_range(0, 4));
                nwCur = (nw == 0) ? 1 : nw;
                loadCfg(nw, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)),
                        {32'(int'($urandom_range(0, 20000)) - 10000), 32'(int'($urandom_range(0, 20000)) - 10000),
                         32'(int'($urandom_range(0, 20000)) - 10000), randLane()});
            end
            if (nwCur > 1 && $urandom_range(0, 6) == 0) begin
                applyStimulus({randLane(), randLane(), randLane(), randLane()});
                doFlush(1'($urandom_range(0, 1)));
            end else begin
                for (int b = 0; b < nwCur; b++) applyStimulus({randLane(), randLane(), randLane(), randLane()});
            end
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        randReady = 1'b0;
        fixedReady = 1'b1;
        waitIdle("final_drain");
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nVectors, nErrors);
        $finish;
    end

endmodule
